// File: rtl/gshare_predictor_if.sv
// Fetch/branch-unit side bundle of the gshare predictor: prediction request/response and resolution update.
// Latency: prediction response is combinational from the request fields; updates commit at the next clock edge.
// Backpressure: none; ready only reports that the table has finished its post-reset clear.
interface gshare_predictor_if #(
    parameter int XLEN     = 64,
    parameter int GHR_BITS = 8
);
    logic                ready;
    logic                predict_valid;
    logic [XLEN-1:0]     pc_fetch;
    logic                predict_taken;
    logic [GHR_BITS-1:0] predict_ghr;
    logic                update_valid;
    logic [XLEN-1:0]     update_pc;
    logic [GHR_BITS-1:0] update_ghr;
    logic                update_taken;
    logic                update_mispredict;

    // Pipeline side: drives fetch requests and branch resolutions.
    modport master (
        input  ready, predict_taken, predict_ghr,
        output predict_valid, pc_fetch,
        output update_valid, update_pc, update_ghr, update_taken, update_mispredict
    );

    // Predictor side.
    modport slave (
        output ready, predict_taken, predict_ghr,
        input  predict_valid, pc_fetch,
        input  update_valid, update_pc, update_ghr, update_taken, update_mispredict
    );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare branch predictor: saturating-counter table indexed by PC XOR speculative global history.
// Latency: prediction is same-cycle combinational; counter/GHR updates land on the next clock edge.
// Backpressure: none; predictions and updates are dropped while the post-reset clear sweep runs (ready=0).
module gshare_predictor #(
    parameter int XLEN     = 64,
    parameter int ENTRIES  = 256,
    parameter int CTR_BITS = 2,
    parameter int GHR_BITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    gshare_predictor_if.slave  bus
);

    localparam int IW = $clog2(ENTRIES);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Weakly not-taken: all ones below the MSB.
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_MIN  = '0;
    localparam logic [IW-1:0]       PTR_LAST = IW'(ENTRIES - 1);

    logic [0:0]          state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic [CTR_BITS-1:0] table_q [ENTRIES];

    logic                running;
    logic [IW-1:0]       fetch_idx;
    logic [IW-1:0]       upd_idx;
    logic [CTR_BITS-1:0] fetch_ctr;
    logic [CTR_BITS-1:0] upd_ctr;
    logic                pred_taken;

    logic                wr_en;
    logic [IW-1:0]       wr_idx;
    logic [CTR_BITS-1:0] wr_dat;

    // Shift one outcome into a history value; written via a wider temporary so
    // GHR_BITS = 1 needs no special case (the old history simply falls off).
    function automatic logic [GHR_BITS-1:0] shift_in(input logic [GHR_BITS-1:0] h,
                                                     input logic                b);
        logic [GHR_BITS:0] t;
        t = {h, b};
        return t[GHR_BITS-1:0];
    endfunction

    assign running = (state_q == ST_RUN) && !rst;

    // Word-aligned PC bits XOR zero-extended history.
    assign fetch_idx = bus.pc_fetch[IW+1:2]  ^ IW'(ghr_q);
    assign upd_idx   = bus.update_pc[IW+1:2] ^ IW'(bus.update_ghr);

    // Read-before-write: both reads see the table as of the start of the cycle.
    assign fetch_ctr  = table_q[fetch_idx];
    assign upd_ctr    = table_q[upd_idx];
    assign pred_taken = running & fetch_ctr[CTR_BITS-1];

    assign bus.ready         = running;
    assign bus.predict_taken = pred_taken;
    assign bus.predict_ghr   = rst ? '0 : ghr_q;

    // Clear sweep: walk every entry once, then hand over to normal operation.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == ST_INIT) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == PTR_LAST) begin
                state_d = ST_RUN;
            end
        end
    end

    // Speculative history: a mispredict restores the history the branch saw plus its real outcome,
    // overriding any fetch-side shift in the same cycle.
    always_comb begin
        ghr_d = ghr_q;
        if (state_q == ST_RUN) begin
            if (bus.update_valid && bus.update_mispredict) begin
                ghr_d = shift_in(bus.update_ghr, bus.update_taken);
            end else if (bus.predict_valid) begin
                ghr_d = shift_in(ghr_q, pred_taken);
            end
        end
    end

    // Single table write port, shared between the clear sweep and resolution training.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        wr_dat = CTR_INIT;
        if (!rst) begin
            if (state_q == ST_INIT) begin
                wr_en = 1'b1;
            end else if (bus.update_valid) begin
                wr_en  = 1'b1;
                wr_idx = upd_idx;
                if (bus.update_taken) begin
                    wr_dat = (upd_ctr == CTR_MAX) ? upd_ctr : upd_ctr + 1'b1;
                end else begin
                    wr_dat = (upd_ctr == CTR_MIN) ? upd_ctr : upd_ctr - 1'b1;
                end
            end
        end
    end

    // Control state and history registers; reset restarts the sweep from entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            ghr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ghr_q   <= ghr_d;
        end
    end

    // Counter storage; contents are only defined once the sweep has passed over them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_q[wr_idx] <= wr_dat;
        end
    end

    // PC bits outside the index window do not participate in the hash.
    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0,
                              bus.pc_fetch[XLEN-1:IW+2],  bus.pc_fetch[1:0],
                              bus.update_pc[XLEN-1:IW+2], bus.update_pc[1:0]};

endmodule
